// File: rtl/scv_aud_out_pkg.sv
// Shared constants, sample type and saturation helper for the APU audio output stage.
// Constants describe the default 6 MHz -> 48 kHz decimation.
package scv_aud_out_pkg;
  localparam int AUD_DECIM     = 125;
  localparam int AUD_RECIP     = 524;
  localparam int AUD_HPF_SHIFT = 10;
  localparam int DC_W          = 27;

  typedef logic signed [15:0] aud_sample_t;

  function automatic aud_sample_t sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7fff;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return aud_sample_t'(v[15:0]);
  endfunction
endpackage

// File: rtl/scv_aud_out_if.sv
// APU-to-mixer audio link: PCM samples in, signed filtered samples out.
// The master side is the APU/mixer glue; the slave side is scv_aud_out.
interface scv_aud_out_if;
  import scv_aud_out_pkg::*;
  logic        aud_ce;
  logic [8:0]  pcm_in;
  logic        mute;
  logic        aud_valid;
  aud_sample_t aud_out;

  modport master (output aud_ce, pcm_in, mute, input aud_valid, aud_out);
  modport slave  (input aud_ce, pcm_in, mute, output aud_valid, aud_out);
endinterface

// File: rtl/scv_aud_out_dcblock.sv
// Output stage: first-order DC blocker (y = x - dc_acc >> HPF_SHIFT), mute and
// the registered output sample with its one-cycle valid strobe.
module scv_aud_out_dcblock
  import scv_aud_out_pkg::*;
#(
  parameter int HPF_SHIFT = AUD_HPF_SHIFT,
  parameter bit HPF_EN    = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        x_vld,
  input  aud_sample_t x,
  input  logic        mute,
  output logic        y_vld,
  output aud_sample_t y
);
  localparam logic signed [DC_W-1:0] DC_MAX = {1'b0, {(DC_W-1){1'b1}}};
  localparam logic signed [DC_W-1:0] DC_MIN = {1'b1, {(DC_W-1){1'b0}}};

  logic signed [DC_W-1:0] dc_acc_q, dc_acc_d;
  logic signed [DC_W:0]   acc_sum;
  logic signed [17:0]     dc, y_unsat;
  aud_sample_t            y_q, y_d, y_pre;
  logic                   y_vld_q, y_vld_d;

  always_comb begin
    dc       = 18'(dc_acc_q >>> HPF_SHIFT);
    y_unsat  = {{2{x[15]}}, x} - dc;
    // Tracker integrates the unclipped error so it keeps converging while y saturates
    acc_sum  = {dc_acc_q[DC_W-1], dc_acc_q} + {{(DC_W-17){y_unsat[17]}}, y_unsat};
    y_pre    = HPF_EN ? sat16(y_unsat) : x;
    dc_acc_d = dc_acc_q;
    y_d      = y_q;
    y_vld_d  = x_vld;
    if (x_vld) begin
      y_d = mute ? '0 : y_pre;
      if (HPF_EN) begin
        if (acc_sum[DC_W] != acc_sum[DC_W-1]) dc_acc_d = acc_sum[DC_W] ? DC_MIN : DC_MAX;
        else                                  dc_acc_d = acc_sum[DC_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dc_acc_q <= '0;
      y_q      <= '0;
      y_vld_q  <= 1'b0;
    end else begin
      dc_acc_q <= dc_acc_d;
      y_q      <= y_d;
      y_vld_q  <= y_vld_d;
    end
  end

  assign y_vld = y_vld_q;
  assign y     = y_q;
endmodule

// File: rtl/scv_aud_out.sv
// uPD1771C audio output: box-filter/decimate 9-bit PCM by DECIM, rescale to
// signed 16-bit, then DC-block and strobe one sample per window to the mixer.
module scv_aud_out
  import scv_aud_out_pkg::*;
#(
  parameter int DECIM     = AUD_DECIM,
  parameter int RECIP     = AUD_RECIP,
  parameter int HPF_SHIFT = AUD_HPF_SHIFT,
  parameter bit HPF_EN    = 1'b1
) (
  input logic          CLK,
  input logic          RESET,
  scv_aud_out_if.slave aud
);
  localparam logic [7:0] LAST = 8'(DECIM - 1);

  logic [15:0] acc_q, acc_d, sum_q, sum_d, pcm_ext;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  vld_pipe_q, vld_pipe_d;
  logic [32:0] prod;
  logic [16:0] avg_raw;
  logic [8:0]  avg;
  aud_sample_t x_q, x_d;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b0};
    pcm_ext    = {7'd0, aud.pcm_in};
    if (aud.aud_ce) begin
      if (cnt_q == LAST) begin
        sum_d         = acc_q + pcm_ext;
        vld_pipe_d[0] = 1'b1;
        acc_d         = '0;
        cnt_d         = '0;
      end else begin
        acc_d = acc_q + pcm_ext;
        cnt_d = cnt_q + 8'd1;
      end
    end

    prod    = {17'd0, sum_q} * 33'(RECIP) + 33'd32768;
    avg_raw = 17'(prod >> 16);
    avg     = (avg_raw > 17'd511) ? 9'd511 : avg_raw[8:0];
    x_d     = x_q;
    // (avg - 256) is avg with its MSB inverted; shift into the top of 16 bits
    if (vld_pipe_q[0]) x_d = {~avg[8], avg[7:0], 7'd0};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      vld_pipe_q <= '0;
      x_q        <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      vld_pipe_q <= vld_pipe_d;
      x_q        <= x_d;
    end
  end

  scv_aud_out_dcblock #(.HPF_SHIFT(HPF_SHIFT), .HPF_EN(HPF_EN)) u_dcblock (
    .CLK   (CLK),
    .RESET (RESET),
    .x_vld (vld_pipe_q[1]),
    .x     (x_q),
    .mute  (aud.mute),
    .y_vld (aud.aud_valid),
    .y     (aud.aud_out)
  );
endmodule

// File: tb/tb_scv_aud_out.sv
// Bench for scv_aud_out: three instances (DECIM 125 with/without DC blocker,
// DECIM 4 with blocker) share one stimulus stream and are scored against a model.
module tb_scv_aud_out;
  import scv_aud_out_pkg::*;
  localparam int ND   = 3;
  localparam int HMAX = 1100;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst = 1'b1, ce = 1'b0, mute = 1'b0;
  logic [8:0] pcm = 9'd256;
  logic       rst_nx = 1'b1, mute_nx = 1'b0;
  bit         chk_en = 1'b0;

  scv_aud_out_if ifa(), ifb(), ifc();
  assign ifa.aud_ce = ce;  assign ifa.pcm_in = pcm;  assign ifa.mute = mute;
  assign ifb.aud_ce = ce;  assign ifb.pcm_in = pcm;  assign ifb.mute = mute;
  assign ifc.aud_ce = ce;  assign ifc.pcm_in = pcm;  assign ifc.mute = mute;

  logic [ND-1:0]       v_obs;
  logic [ND-1:0][15:0] o_obs;
  assign v_obs[0] = ifa.aud_valid;  assign o_obs[0] = ifa.aud_out;
  assign v_obs[1] = ifb.aud_valid;  assign o_obs[1] = ifb.aud_out;
  assign v_obs[2] = ifc.aud_valid;  assign o_obs[2] = ifc.aud_out;

  scv_aud_out #(.DECIM(125), .RECIP(524), .HPF_SHIFT(10), .HPF_EN(1'b1))
    dut_a (.CLK(CLK), .RESET(rst), .aud(ifa));
  scv_aud_out #(.DECIM(125), .RECIP(524), .HPF_SHIFT(10), .HPF_EN(1'b0))
    dut_b (.CLK(CLK), .RESET(rst), .aud(ifb));
  scv_aud_out #(.DECIM(4), .RECIP(16384), .HPF_SHIFT(10), .HPF_EN(1'b1))
    dut_c (.CLK(CLK), .RESET(rst), .aud(ifc));

  function automatic int  dec_of(input int k);   return (k == 2) ? 4 : 125;       endfunction
  function automatic int  recip_of(input int k); return (k == 2) ? 16384 : 524;   endfunction
  function automatic bit  hpf_of(input int k);   return k != 1;                   endfunction

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: window sums, pending outputs with due cycle, DC tracker as integers
  typedef struct { int k; int due; int y; } pend_t;
  pend_t  pq[$];
  int     cnt[ND], last_out[ND], nh[ND];
  longint sum[ND], dcacc[ND];
  int     hist[ND][0:HMAX-1], hcyc[ND][0:HMAX-1];
  int     cyc = 0;

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int model_y(input int k, input longint s);
    longint avg, x, dc, yu, y, na;
    avg = (s * recip_of(k) + 32768) / 65536;
    if (avg > 511) avg = 511;
    x = (avg - 256) * 128;
    if (!hpf_of(k)) return int'(x);
    dc = floor_div(dcacc[k], 1024);
    yu = x - dc;
    y  = (yu > 32767) ? 32767 : ((yu < -32768) ? -32768 : yu);
    na = dcacc[k] + yu;
    if (na > 64'sd67108863)  na = 64'sd67108863;
    if (na < -64'sd67108864) na = -64'sd67108864;
    dcacc[k] = na;
    return int'(y);
  endfunction

  task automatic model_in(input bit r, input bit c, input int p);
    pend_t e;
    for (int k = 0; k < ND; k++) begin
      if (r) begin
        cnt[k] = 0; sum[k] = 0; dcacc[k] = 0; last_out[k] = 0;
      end else if (c) begin
        sum[k] += p;
        cnt[k]++;
        if (cnt[k] == dec_of(k)) begin
          e.k = k; e.due = cyc + 3; e.y = model_y(k, sum[k]);
          pq.push_back(e);
          cnt[k] = 0; sum[k] = 0;
        end
      end
    end
    if (r) pq.delete();
  endtask

  task automatic check_outputs();
    for (int k = 0; k < ND; k++) begin
      int idx, y, e;
      bit ev;
      idx = -1; ev = 1'b0; y = 0;
      for (int i = 0; i < pq.size(); i++) if (idx < 0 && pq[i].k == k) idx = i;
      if (idx >= 0 && pq[idx].due == cyc) begin
        ev = 1'b1; y = pq[idx].y; pq.delete(idx);
      end
      chk($sformatf("valid%0d", k), 64'(v_obs[k]), 64'(ev));
      if (ev) begin
        e = mute ? 0 : y;
        chk($sformatf("out%0d", k), 64'($signed(o_obs[k])), 64'(e));
        last_out[k] = e;
        if (nh[k] < HMAX) begin
          hist[k][nh[k]] = int'($signed(o_obs[k]));
          hcyc[k][nh[k]] = cyc;
        end
        nh[k]++;
      end else begin
        chk($sformatf("hold%0d", k), 64'($signed(o_obs[k])), 64'(last_out[k]));
      end
    end
  endtask

  task automatic step(input bit c, input int p);
    @(negedge CLK);
    if (chk_en) check_outputs();
    rst  = rst_nx;
    mute = mute_nx;
    ce   = c;
    pcm  = 9'(p);
    model_in(rst_nx, c, p);
    cyc++;
  endtask

  task automatic pulse(input int p, input int gap);
    step(1'b1, p);
    for (int g = 1; g < gap; g++) step(1'b0, p);
  endtask

  task automatic do_reset();
    rst_nx = 1'b1;
    step(1'b0, 256);
    rst_nx = 1'b0;
    for (int k = 0; k < ND; k++) nh[k] = 0;
    step(1'b0, 256);
  endtask

  initial begin
    int wend[10];
    int w, ce_c, base, pj;
    step(1'b0, 256);
    step(1'b0, 256);
    chk_en = 1'b1;
    do_reset();
    for (int k = 0; k < ND; k++) begin
      chk("rst_vld", 64'(v_obs[k]), 0);
      chk("rst_out", 64'($signed(o_obs[k])), 0);
    end

    // Silence, CE every 5 CLK: ten windows of zero, 625-CLK period, 3-CLK latency
    w = 0;
    for (int i = 0; i < 1250; i++) begin
      if (i % 125 == 124) begin wend[w] = cyc; w++; end
      pulse(256, 5);
    end
    chk("p1_count", 64'(nh[0]), 10);
    for (int j = 0; j < 10; j++) begin
      chk("p1_zero", 64'(hist[0][j]), 0);
      chk("p1_lat", 64'(hcyc[0][j] - wend[j]), 3);
      if (j > 0) chk("p1_period", 64'(hcyc[0][j] - hcyc[0][j-1]), 625);
    end

    // Full-scale steps: bypass rails, blocker's first two outputs
    do_reset();
    for (int i = 0; i < 250; i++) pulse(511, 4);
    for (int i = 0; i < 250; i++) pulse(0, 4);
    chk("p2_count", 64'(nh[1]), 4);
    chk("p2_byp_hi0", 64'(hist[1][0]), 32640);
    chk("p2_byp_hi1", 64'(hist[1][1]), 32640);
    chk("p2_byp_lo0", 64'(hist[1][2]), -32768);
    chk("p2_byp_lo1", 64'(hist[1][3]), -32768);
    chk("p2_hpf_0", 64'(hist[0][0]), 32640);
    chk("p2_hpf_1", 64'(hist[0][1]), 32609);

    // Long step response on the short-window instance
    do_reset();
    for (int i = 0; i < 4096; i++) pulse(511, 4);
    chk("p3_count", 64'(nh[2]), 1024);
    chk("p3_s0", 64'(hist[2][0]), 32640);
    chk("p3_s1", 64'(hist[2][1]), 32609);
    for (int j = 1; j < 1024; j++) chk("p3_mono", 64'(hist[2][j] <= hist[2][j-1]), 1);
    chk("p3_decay", 64'(hist[2][1023] < 12100), 1);

    // Reset mid-window: next window counts from the first CE after reset
    do_reset();
    for (int i = 0; i < 60; i++) pulse(511, 4);
    do_reset();
    ce_c = 0;
    for (int i = 0; i < 125; i++) begin
      if (i == 124) ce_c = cyc;
      pulse(256, 4);
    end
    chk("p4_count", 64'(nh[0]), 1);
    chk("p4_out", 64'(hist[0][0]), 0);
    chk("p4_lat", 64'(hcyc[0][0] - ce_c), 3);

    // Reset while a completed window is in the pipeline drops it
    do_reset();
    for (int i = 0; i < 124; i++) pulse(511, 4);
    step(1'b1, 511);
    step(1'b0, 511);
    rst_nx = 1'b1;
    step(1'b0, 256);
    rst_nx = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 256);
    chk("p4_drop", 64'(nh[0]), 0);

    // Mute during a step; tracker keeps running underneath
    do_reset();
    mute_nx = 1'b1;
    for (int i = 0; i < 80; i++) pulse(511, 4);
    mute_nx = 1'b0;
    for (int i = 0; i < 80; i++) pulse(511, 4);
    chk("p5_count", 64'(nh[2]), 40);
    for (int j = 0; j < 20; j++) chk("p5_muted", 64'(hist[2][j]), 0);
    chk("p5_decayed", 64'(hist[2][20] > 31000 && hist[2][20] < 32600), 1);

    // Settle low then step high: clip at +32767, then alternate with no wrap
    do_reset();
    for (int i = 0; i < 800; i++) pulse(0, 4);
    for (int i = 0; i < 4; i++) pulse(511, 4);
    chk("p6_sat", 64'(hist[2][200]), 32767);
    base = nh[2];
    for (int j = 0; j < 40; j++) begin
      pj = (j % 2 == 0) ? 0 : 511;
      for (int i = 0; i < 4; i++) pulse(pj, 4);
    end
    for (int j = 0; j < 40; j++) begin
      if (j % 2 == 0) chk("p6_alt_lo", 64'(hist[2][base + j] < 0), 1);
      else            chk("p6_alt_hi", 64'(hist[2][base + j] > 0), 1);
    end

    // Random PCM, spacing, mute and sporadic resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) mute_nx = ~mute_nx;
      if ($urandom_range(0, 999) == 0) begin
        rst_nx = 1'b1;
        step(1'b0, 256);
        rst_nx = 1'b0;
      end
      pulse(int'($urandom_range(0, 511)), int'($urandom_range(4, 7)));
    end
    mute_nx = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 256);
    chk("p7_drain", 64'(pq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
